// File: rtl/mem_pkg.sv
// Shared widths, boot-sequencer state type and the blank word
// used by the program/data memory slice.
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        RUN
    } state_t;

    localparam logic [DATA_W-1:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/program_data_memory_if.sv
// Core/loader bus of the program/data memory.
// Ports: fetch (instr_addr/instr), load-store (mem_*),
// loader handshake (prog_*), status (cpu_ready, wr_fault).
// master = core + loader side, slave = memory side.
interface program_data_memory_if
    import mem_pkg::*;
;
    logic [ADDR_W-1:0] instr_addr;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_store_en;
    logic [DATA_W-1:0] mem_store_val;
    logic [DATA_W-1:0] mem_load_val;
    logic              prog_valid;
    logic              prog_ready;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              cpu_ready;
    logic              wr_fault;

    modport master (
        output instr_addr, mem_addr, mem_store_en, mem_store_val,
        output prog_valid, prog_addr, prog_data, prog_last,
        input  instr, mem_load_val, prog_ready, cpu_ready, wr_fault
    );

    modport slave (
        input  instr_addr, mem_addr, mem_store_en, mem_store_val,
        input  prog_valid, prog_addr, prog_data, prog_last,
        output instr, mem_load_val, prog_ready, cpu_ready, wr_fault
    );

endinterface

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port,
// two asynchronous read ports (a = fetch, b = load).
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/program_data_memory.sv
// Program/data memory with boot sequencer CLEAR -> LOAD -> RUN.
// Ports: clk, rst (sync, active-high), bus (slave modport).
// Option: MEM_WRITE_FORWARD_EN forwards accepted stores to same-cycle reads.
module program_data_memory
    import mem_pkg::*;
#(
    parameter int                DEPTH      = 2 ** ADDR_W,
    parameter logic [ADDR_W-1:0] TEXT_LIMIT = 8'h80
) (
    input  logic                  clk,
    input  logic                  rst,
    program_data_memory_if.slave  bus
);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              prog_ready_q;
    logic              cpu_ready_q;
    logic              wr_fault_q;

    logic              load_xfer;
    logic              store_ok;
    logic              store_bad;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_instr;
    logic [DATA_W-1:0] rd_load;

    always_comb begin
        load_xfer = (state == LOAD) && bus.prog_valid && prog_ready_q;
        store_ok  = (state == RUN) && bus.mem_store_en
                    && (bus.mem_addr >= TEXT_LIMIT);
        store_bad = (state == RUN) && bus.mem_store_en
                    && (bus.mem_addr < TEXT_LIMIT);
    end

    // Each state owns the single write port exclusively.
    always_comb begin
        we    = 1'b0;
        waddr = clr_cnt;
        wdata = NOP_WORD;
        unique case (state)
            CLEAR: begin
                we = !rst;
            end
            LOAD: begin
                we    = load_xfer && !rst;
                waddr = bus.prog_addr;
                wdata = bus.prog_data;
            end
            RUN: begin
                we    = store_ok && !rst;
                waddr = bus.mem_addr;
                wdata = bus.mem_store_val;
            end
            default: we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            prog_ready_q <= 1'b0;
            cpu_ready_q  <= 1'b0;
            wr_fault_q   <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state        <= LOAD;
                        prog_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_xfer && bus.prog_last) begin
                        state        <= RUN;
                        prog_ready_q <= 1'b0;
                        cpu_ready_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (store_bad) begin
                        wr_fault_q <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (bus.instr_addr),
        .rdata_a (rd_instr),
        .raddr_b (bus.mem_addr),
        .rdata_b (rd_load)
    );

    // Reads are blanked until the image is loaded.
    always_comb begin
        bus.instr        = NOP_WORD;
        bus.mem_load_val = NOP_WORD;
        if (state == RUN) begin
            bus.instr        = rd_instr;
            bus.mem_load_val = rd_load;
`ifdef MEM_WRITE_FORWARD_EN
            if (store_ok && (bus.instr_addr == bus.mem_addr)) begin
                bus.instr = bus.mem_store_val;
            end
            if (store_ok) begin
                bus.mem_load_val = bus.mem_store_val;
            end
`endif
        end
    end

    assign bus.prog_ready = prog_ready_q;
    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.wr_fault   = wr_fault_q;

endmodule

// File: tb/tb_program_data_memory.sv
// Self-checking bench for program_data_memory: boot sequence,
// loader, protected stores, same-cycle store/read, reset mid-load.
module tb_program_data_memory;

    logic clk = 1'b0;
    logic rst = 1'b1;

    program_data_memory_if bus ();

    program_data_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] model_mem [256];
    bit          model_fault;
    int          passed = 0;
    int          total  = 0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.instr_addr    = 8'h00;
        bus.mem_addr      = 8'h00;
        bus.mem_store_en  = 1'b0;
        bus.mem_store_val = 16'h0000;
        bus.prog_valid    = 1'b0;
        bus.prog_addr     = 8'h00;
        bus.prog_data     = 16'h0000;
        bus.prog_last     = 1'b0;
    endtask

    task automatic model_clear;
        for (int a = 0; a < 256; a++) model_mem[a] = 16'h0000;
        model_fault = 1'b0;
    endtask

    task automatic pulse_reset;
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d,
                             input bit last);
        int n;
        n = 0;
        bus.prog_valid = 1'b1;
        bus.prog_addr  = a;
        bus.prog_data  = d;
        bus.prog_last  = last;
        while (bus.prog_ready !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            total++;
            $display("FAIL ready_timeout: waited %0d cycles, need prog_ready=1", n);
        end
        step();
        model_mem[a]   = d;
        bus.prog_valid = 1'b0;
        bus.prog_last  = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        bad = 0;
        pulse_reset();
        #1;
        total++;
        if (bus.cpu_ready !== 1'b0) $display("FAIL rst_cpu_ready: got %b need 0", bus.cpu_ready);
        else passed++;
        total++;
        if (bus.prog_ready !== 1'b0) $display("FAIL rst_prog_ready: got %b need 0", bus.prog_ready);
        else passed++;
        total++;
        if (bus.wr_fault !== 1'b0) $display("FAIL rst_wr_fault: got %b need 0", bus.wr_fault);
        else passed++;
        total++;
        if (bus.instr !== 16'h0) $display("FAIL rst_instr: got %h need 0000", bus.instr);
        else passed++;
        total++;
        if (bus.mem_load_val !== 16'h0) $display("FAIL rst_load: got %h need 0000", bus.mem_load_val);
        else passed++;
        // Cycles 1..256 after reset: clearing, loader and stores ignored.
        for (int i = 1; i <= 256; i++) begin
            if (i <= 200) begin
                bus.prog_valid    = 1'b1;
                bus.prog_addr     = 8'h40;
                bus.prog_data     = 16'hDEAD;
                bus.prog_last     = 1'b1;
                bus.mem_store_en  = 1'b1;
                bus.mem_addr      = 8'hC0;
                bus.mem_store_val = 16'hBEEF;
            end else begin
                idle_inputs();
            end
            bus.instr_addr = 8'($urandom);
            #1;
            if (bus.prog_ready !== 1'b0 || bus.cpu_ready !== 1'b0 ||
                bus.instr !== 16'h0 || bus.mem_load_val !== 16'h0) bad++;
            step();
        end
        total++;
        if (bad != 0) $display("FAIL clear_window: %0d bad cycles, need 0", bad);
        else passed++;
        total++;
        if (bus.prog_ready !== 1'b1) $display("FAIL ready_cycle_257: got %b need 1", bus.prog_ready);
        else passed++;
        total++;
        if (bus.cpu_ready !== 1'b0) $display("FAIL cpu_ready_in_load: got %b need 0", bus.cpu_ready);
        else passed++;
    endtask

    task automatic test_load;
        int bad;
        logic [7:0] a;
        bad = 0;
        load_word(8'h00, 16'hA001, 1'b0);
        bus.instr_addr = 8'h00;
        bus.mem_addr   = 8'h00;
        #1;
        total++;
        if (bus.instr !== 16'h0 || bus.mem_load_val !== 16'h0)
            $display("FAIL load_gated: got %h/%h need 0000/0000", bus.instr, bus.mem_load_val);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) step();
            if (i[0]) a = 8'($urandom_range(3, 63));
            else a = 8'($urandom_range(160, 255));
            load_word(a, 16'($urandom), 1'b0);
        end
        load_word(8'h01, 16'hB002, 1'b0);
        load_word(8'h02, 16'hC003, 1'b1);
        total++;
        if (bus.cpu_ready !== 1'b1) $display("FAIL cpu_ready_after_last: got %b need 1", bus.cpu_ready);
        else passed++;
        total++;
        if (bus.prog_ready !== 1'b0) $display("FAIL prog_ready_in_run: got %b need 0", bus.prog_ready);
        else passed++;
        bus.instr_addr = 8'h01;
        #1;
        total++;
        if (bus.instr !== 16'hB002) $display("FAIL fetch_01: got %h need B002", bus.instr);
        else passed++;
        for (int i = 0; i < 256; i++) begin
            bus.instr_addr = 8'(i);
            bus.mem_addr   = 8'(255 - i);
            #1;
            if (bus.instr !== model_mem[i] ||
                bus.mem_load_val !== model_mem[255 - i]) begin
                if (bad == 0)
                    $display("FAIL image_sweep: addr %0d got %h need %h", i, bus.instr, model_mem[i]);
                bad++;
            end
        end
        total++;
        if (bad == 0) passed++;
    endtask

    task automatic test_store;
        logic [7:0]  a;
        logic [15:0] d;
        bus.mem_addr      = 8'h90;
        bus.mem_store_val = 16'h1234;
        bus.mem_store_en  = 1'b1;
        step();
        bus.mem_store_en = 1'b0;
        model_mem[8'h90] = 16'h1234;
        #1;
        total++;
        if (bus.mem_load_val !== 16'h1234) $display("FAIL store_90: got %h need 1234", bus.mem_load_val);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom_range(145, 255));
            d = 16'($urandom);
            bus.mem_addr      = a;
            bus.mem_store_val = d;
            bus.mem_store_en  = 1'b1;
            step();
            bus.mem_store_en = 1'b0;
            model_mem[a]     = d;
            bus.instr_addr   = a;
            #1;
            total++;
            if (bus.mem_load_val !== model_mem[a] || bus.instr !== model_mem[a])
                $display("FAIL rand_store: addr %h got %h/%h need %h", a, bus.mem_load_val, bus.instr, model_mem[a]);
            else passed++;
        end
        total++;
        if (bus.wr_fault !== 1'b0) $display("FAIL no_fault: got %b need 0", bus.wr_fault);
        else passed++;
    endtask

    task automatic test_protect;
        logic [7:0] a;
        bus.mem_addr      = 8'h10;
        bus.mem_store_val = 16'hFFFF;
        bus.mem_store_en  = 1'b1;
        step();
        bus.mem_store_en = 1'b0;
        model_fault      = 1'b1;
        #1;
        total++;
        if (bus.mem_load_val !== model_mem[8'h10])
            $display("FAIL protect_10: got %h need %h", bus.mem_load_val, model_mem[8'h10]);
        else passed++;
        total++;
        if (bus.wr_fault !== model_fault) $display("FAIL fault_set: got %b need 1", bus.wr_fault);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            a = i[0] ? 8'($urandom_range(0, 127)) : 8'($urandom_range(160, 255));
            bus.mem_addr      = a;
            bus.mem_store_val = 16'($urandom);
            bus.mem_store_en  = 1'b1;
            step();
            bus.mem_store_en = 1'b0;
            if (a >= 8'h80) model_mem[a] = bus.mem_store_val;
            #1;
            total++;
            if (bus.mem_load_val !== model_mem[a] || bus.wr_fault !== 1'b1)
                $display("FAIL protect_mix: addr %h got %h/%b need %h/1", a, bus.mem_load_val, bus.wr_fault, model_mem[a]);
            else passed++;
        end
    endtask

    task automatic test_same_cycle;
        logic [15:0] exp_w;
        bus.mem_addr      = 8'h90;
        bus.instr_addr    = 8'h90;
        bus.mem_store_val = 16'h5555;
        bus.mem_store_en  = 1'b1;
`ifdef MEM_WRITE_FORWARD_EN
        exp_w = 16'h5555;
`else
        exp_w = model_mem[8'h90];
`endif
        #1;
        total++;
        if (bus.mem_load_val !== exp_w || bus.instr !== exp_w)
            $display("FAIL same_cycle_90: got %h/%h need %h", bus.mem_load_val, bus.instr, exp_w);
        else passed++;
        step();
        bus.mem_store_en = 1'b0;
        model_mem[8'h90] = 16'h5555;
        #1;
        total++;
        if (bus.mem_load_val !== 16'h5555 || bus.instr !== 16'h5555)
            $display("FAIL after_5555: got %h/%h need 5555", bus.mem_load_val, bus.instr);
        else passed++;
        bus.mem_addr      = 8'h20;
        bus.instr_addr    = 8'h20;
        bus.mem_store_val = 16'h7777;
        bus.mem_store_en  = 1'b1;
        #1;
        total++;
        if (bus.mem_load_val !== model_mem[8'h20] || bus.instr !== model_mem[8'h20])
            $display("FAIL dropped_no_fwd: got %h/%h need %h", bus.mem_load_val, bus.instr, model_mem[8'h20]);
        else passed++;
        step();
        bus.mem_addr      = 8'hA5;
        bus.instr_addr    = 8'h02;
        bus.mem_store_val = 16'h6666;
        #1;
        total++;
        if (bus.instr !== model_mem[8'h02])
            $display("FAIL fwd_other_port: got %h need %h", bus.instr, model_mem[8'h02]);
        else passed++;
        step();
        bus.mem_store_en = 1'b0;
        model_mem[8'hA5] = 16'h6666;
    endtask

    task automatic test_reset_midload;
        logic [15:0] d;
        int bad;
        bad = 0;
        d = 16'($urandom) | 16'h0001;
        pulse_reset();
        load_word(8'h00, 16'hA001, 1'b0);
        pulse_reset();
        #1;
        total++;
        if (bus.prog_ready !== 1'b0 || bus.cpu_ready !== 1'b0 || bus.wr_fault !== 1'b0)
            $display("FAIL midload_rst: got %b%b%b need 000", bus.prog_ready, bus.cpu_ready, bus.wr_fault);
        else passed++;
        load_word(8'h05, d, 1'b1);
        bus.instr_addr = 8'h00;
        bus.mem_addr   = 8'h05;
        #1;
        total++;
        if (bus.instr !== 16'h0000 || bus.mem_load_val !== d)
            $display("FAIL reload: got %h/%h need 0000/%h", bus.instr, bus.mem_load_val, d);
        else passed++;
        for (int i = 0; i < 256; i++) begin
            bus.mem_addr = 8'(i);
            #1;
            if (bus.mem_load_val !== model_mem[i]) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL reload_sweep: %0d bad words, need 0", bad);
        else passed++;
    endtask

    initial begin
        idle_inputs();
        model_clear();
        test_reset();
        test_load();
        test_store();
        test_protect();
        test_same_cycle();
        test_reset_midload();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
